// File: rtl/ctrl_trace_encoder.sv
// rtl/ctrl_trace_encoder.sv - re-encodes control bundles to opcodes into a timestamped FWFT trace FIFO
module ctrl_trace_encoder #(
  parameter int DEPTH    = 8,
  parameter int TS_W     = 10,
  parameter int DROP_NOP = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       ctl_valid,
  input  logic                       reg_write,
  input  logic [1:0]                 alu_op,
  input  logic                       reg_dst,
  input  logic                       alu_src,
  input  logic                       mem_write,
  input  logic                       mem_read,
  input  logic                       mem_to_reg,
  input  logic                       branch,
  input  logic                       jump,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W+6:0]            out_data,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + 7;

  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            overflow_q;
  logic [7:0]      drop_cnt_q;

  logic [5:0]      enc_opcode;
  logic            enc_illegal;
  logic            enc_nop;
  logic            full, pop, push_req, push, drop;

  // Inverse control decode: first matching bundle pattern selects the opcode
  always_comb begin
    enc_opcode  = 6'b111110;
    enc_illegal = 1'b1;
    enc_nop     = 1'b0;
    if (reg_write && reg_dst && !alu_src && !mem_read && !mem_write && alu_op == 2'b10) begin
      enc_opcode = 6'b000000; enc_illegal = 1'b0;
    end else if (reg_write && mem_read && mem_to_reg && alu_src && !reg_dst && !mem_write
                 && alu_op == 2'b00) begin
      enc_opcode = 6'b010001; enc_illegal = 1'b0;
    end else if (reg_write && !reg_dst && alu_src && !mem_read && !mem_write && !mem_to_reg
                 && alu_op == 2'b00) begin
      enc_opcode = 6'b001100; enc_illegal = 1'b0;
    end else if (reg_write && !reg_dst && alu_src && !mem_read && !mem_write && !mem_to_reg
                 && alu_op == 2'b01) begin
      enc_opcode = 6'b001101; enc_illegal = 1'b0;
    end else if (mem_write && !reg_write && !mem_read && alu_src && !branch && !jump
                 && alu_op == 2'b00) begin
      enc_opcode = 6'b010000; enc_illegal = 1'b0;
    end else if (branch && !jump && !alu_src && !reg_write && !mem_write && !mem_read
                 && alu_op == 2'b01) begin
      enc_opcode = 6'b010011; enc_illegal = 1'b0;
    end else if (jump && !branch && !reg_write && !mem_write && !mem_read && alu_op == 2'b01) begin
      enc_opcode = 6'b011100; enc_illegal = 1'b0;
    end else if (!reg_write && !mem_write && !mem_read && !branch && !jump && alu_op == 2'b11) begin
      enc_opcode = 6'b111111; enc_illegal = 1'b0; enc_nop = 1'b1;
    end
  end

  // Pop only when something is visible; a pop frees room for a push in the same cycle
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = (count_q != '0) && out_ready;
    push_req = ctl_valid && !(enc_nop && (DROP_NOP != 0));
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Free-running timestamp, wraps naturally at 2^TS_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ts_q <= '0;
    else if (clr) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  // Entry storage; contents are only observed through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, enc_illegal, enc_opcode};
  end

  // Pointers, occupancy and drop bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Head is driven only from registers; zero while empty
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
    level     = count_q;
  end

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// tb/tb_ctrl_trace_encoder.sv - randomized model-checked bench for ctrl_trace_encoder
module tb_ctrl_trace_encoder;

  localparam int DEPTH    = 8;
  localparam int TS_W     = 10;
  localparam int DROP_NOP = 1;
  localparam int DW       = TS_W + 7;

  // bundle bits: [9]RegWrite [8:7]ALUOp [6]RegDst [5]ALUSrc [4]MemWrite [3]MemRead [2]MemtoReg [1]Branch [0]Jump
  localparam logic [9:0] R_MASK [8] = '{10'b1111111000, 10'b1111111100, 10'b1111111100, 10'b1111111100,
                                        10'b1110111011, 10'b1110111011, 10'b1110011011, 10'b1110011011};
  localparam logic [9:0] R_VAL  [8] = '{10'b1101000000, 10'b1000101100, 10'b1000100000, 10'b1010100000,
                                        10'b0000110000, 10'b0010000010, 10'b0010000001, 10'b0110000000};
  localparam logic [5:0] R_OP   [8] = '{6'b000000, 6'b010001, 6'b001100, 6'b001101,
                                        6'b010000, 6'b010011, 6'b011100, 6'b111111};

  logic clk, rst_n, clr, ctl_valid, out_ready;
  logic [9:0] bnd;
  logic out_valid, overflow;
  logic [DW-1:0] out_data;
  logic [7:0] drop_cnt;
  logic [$clog2(DEPTH):0] level;

  ctrl_trace_encoder #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_NOP(DROP_NOP)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ctl_valid(ctl_valid),
    .reg_write(bnd[9]), .alu_op(bnd[8:7]), .reg_dst(bnd[6]), .alu_src(bnd[5]),
    .mem_write(bnd[4]), .mem_read(bnd[3]), .mem_to_reg(bnd[2]), .branch(bnd[1]), .jump(bnd[0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [DW-1:0] mq[$];
  int m_ts;
  bit m_ovf;
  int m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_encode(input logic [9:0] b, output logic [5:0] op,
                                       output bit ill, output bit nop);
    op = 6'b111110; ill = 1'b1; nop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((b & R_MASK[i]) == R_VAL[i]) begin
        op = R_OP[i]; ill = 1'b0; nop = (i == 7);
        return;
      end
    end
  endfunction

  task automatic model_reset();
    mq.delete(); m_ts = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_clock();
    logic [5:0] op; bit ill, nop;
    if (clr) begin
      model_reset();
      return;
    end
    model_encode(bnd, op, ill, nop);
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (ctl_valid && !(nop && DROP_NOP != 0)) begin
      if (mq.size() < DEPTH) mq.push_back({TS_W'(m_ts), ill, op});
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
  endtask

  function automatic logic [9:0] rand_bundle();
    int k;
    logic [9:0] r;
    k = $urandom_range(0, 9);
    r = 10'($urandom);
    if (k < 8) return (R_VAL[k] & R_MASK[k]) | (r & ~R_MASK[k]);
    return r;
  endfunction

  // Compare process: every cycle, DUT state against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  int seq_idx [7] = '{0, 2, 3, 4, 1, 5, 6};
  logic [5:0] seq_op [7] = '{6'b000000, 6'b001100, 6'b001101, 6'b010000, 6'b010001, 6'b010011, 6'b011100};

  initial begin
    rst_n = 0; clr = 0; ctl_valid = 0; bnd = '0; out_ready = 0;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1; chk_en = 1;

    // first entry sampled at ts=5
    repeat (5) step();
    ctl_valid = 1; bnd = R_VAL[0]; step(); ctl_valid = 0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'h280);
    chk("t1_level", 32'(level), 1);

    // seven legal bundles back to back, reader always ready
    out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      ctl_valid = 1; bnd = R_VAL[seq_idx[i]]; step();
      chk("seq_opcode", 32'(out_data[5:0]), 32'(seq_op[i]));
      chk("seq_illegal", 32'(out_data[6]), 0);
      chk("seq_ts", 32'(out_data[DW-1:7]), 32'(6 + i));
    end
    ctl_valid = 0; step();

    // NOP is not enqueued, conflicting memory controls are illegal
    ctl_valid = 1; bnd = R_VAL[7]; step();
    chk("nop_level", 32'(level), 0);
    bnd = 10'b0000011000; step();
    chk("illegal_entry", 32'(out_data[6:0]), 32'h7E);
    ctl_valid = 0; step();

    // overflow: ten pushes into eight slots
    out_ready = 0; ctl_valid = 1;
    for (int i = 0; i < 10; i++) begin
      bnd = R_VAL[i % 7]; step();
    end
    chk("ovf_level", 32'(level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_cnt), 2);
    chk("ovf_head", 32'(out_data[5:0]), 0);
    out_ready = 1; bnd = R_VAL[2]; step();
    chk("full_pp_level", 32'(level), 8);
    chk("full_pp_drops", 32'(drop_cnt), 2);
    chk("full_pp_head", 32'(out_data[5:0]), 32'h11);

    // drain to three entries then synchronous clear
    ctl_valid = 0;
    repeat (5) step();
    chk("pre_clr_level", 32'(level), 3);
    clr = 1; step(); clr = 0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_level", 32'(level), 0);
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_drops", 32'(drop_cnt), 0);

    // timestamp wrap: 1024 idle cycles after clear, then ts 0..6
    out_ready = 0;
    repeat (1024) step();
    ctl_valid = 1;
    for (int i = 0; i < 7; i++) begin
      bnd = R_VAL[i]; step();
    end
    ctl_valid = 0; out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      chk("wrap_ts", 32'(out_data[DW-1:7]), 32'(i));
      step();
    end

    // three entries with overflow, then asynchronous reset mid-cycle
    out_ready = 0; ctl_valid = 1;
    repeat (9) begin bnd = R_VAL[$urandom_range(0, 6)]; step(); end
    ctl_valid = 0; out_ready = 1;
    repeat (5) step();
    chk("pre_rst_level", 32'(level), 3);
    #2 rst_n = 0; model_reset();
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_drops", 32'(drop_cnt), 0);
    @(negedge clk); rst_n = 1;
    ctl_valid = 1; bnd = R_VAL[4]; out_ready = 0; step(); ctl_valid = 0;
    chk("post_rst_ts", 32'(out_data[DW-1:7]), 0);

    // drop counter saturation
    ctl_valid = 1; bnd = R_VAL[1];
    repeat (270) step();
    chk("drop_sat", 32'(drop_cnt), 255);
    ctl_valid = 0; clr = 1; step(); clr = 0;

    // randomized traffic with alternating reader pressure
    for (int n = 0; n < 3000; n++) begin
      ctl_valid = ($urandom_range(0, 9) < 7);
      bnd = rand_bundle();
      if (((n / 64) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
      else out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      step();
    end
    clr = 0; ctl_valid = 0;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
